// File: rtl/seq_fixed_div.sv
// Sign-magnitude Q-format divider: restoring long division, one quotient bit per cycle.
// Optional reciprocal mode and a pass-through channel tag so one instance serves many channels.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// CALC  | one quotient bit per cycle, MSB first
// DONE  | result registered; out_valid rises one edge later and holds until taken
module seq_fixed_div #(
  parameter int N     = 32,
  parameter int Q     = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_recip,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             out_dz
);

  localparam int QW = N - 1 + Q;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [QW-1:0]    dvd, dvd_nxt;
  logic [QW-1:0]    quo, quo_nxt;
  logic [N-1:0]     rem, rem_nxt;
  logic [N-2:0]     b_mag, b_mag_nxt;
  logic             sign, sign_nxt;
  logic [TAG_W-1:0] tag, tag_nxt;
  logic [N-1:0]     q_nxt;
  logic [TAG_W-1:0] out_tag_nxt;
  logic             ovf_nxt, dz_nxt, valid_nxt;

  logic [N-2:0]     a_abs;
  logic             sa;
  logic [N-1:0]     rem_sh;
  logic             qbit;
  logic [QW-1:0]    quo_full;
  logic [N-2:0]     mag;
  logic             ovf_c;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      quo       <= '0;
      rem       <= '0;
      b_mag     <= '0;
      sign      <= 1'b0;
      tag       <= '0;
      out_q     <= '0;
      out_tag   <= '0;
      out_ovf   <= 1'b0;
      out_dz    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dvd       <= dvd_nxt;
      quo       <= quo_nxt;
      rem       <= rem_nxt;
      b_mag     <= b_mag_nxt;
      sign      <= sign_nxt;
      tag       <= tag_nxt;
      out_q     <= q_nxt;
      out_tag   <= out_tag_nxt;
      out_ovf   <= ovf_nxt;
      out_dz    <= dz_nxt;
      out_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    dvd_nxt     = dvd;
    quo_nxt     = quo;
    rem_nxt     = rem;
    b_mag_nxt   = b_mag;
    sign_nxt    = sign;
    tag_nxt     = tag;
    q_nxt       = out_q;
    out_tag_nxt = out_tag;
    ovf_nxt     = out_ovf;
    dz_nxt      = out_dz;
    valid_nxt   = out_valid;
    a_abs       = '0;
    sa          = 1'b0;
    rem_sh      = '0;
    qbit        = 1'b0;
    quo_full    = '0;
    mag         = '0;
    ovf_c       = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_recip) begin
            a_abs[Q] = 1'b1;
          end else begin
            a_abs = in_a[N-2:0];
            sa    = in_a[N-1];
          end
          sign_nxt  = sa ^ in_b[N-1];
          b_mag_nxt = in_b[N-2:0];
          tag_nxt   = in_tag;
          if (in_b[N-2:0] == '0) begin
            // Divide by zero (either sign of zero) saturates with the dividend's sign.
            q_nxt       = {sa, {(N-1){1'b1}}};
            out_tag_nxt = in_tag;
            ovf_nxt     = 1'b0;
            dz_nxt      = 1'b1;
            state_nxt   = DONE;
          end else begin
            dvd_nxt   = {a_abs, {Q{1'b0}}};
            quo_nxt   = '0;
            rem_nxt   = '0;
            cnt_nxt   = CW'(QW - 1);
            state_nxt = CALC;
          end
        end
      end

      CALC: begin
        rem_sh   = {rem[N-2:0], dvd[QW-1]};
        qbit     = (rem_sh >= {1'b0, b_mag});
        rem_nxt  = qbit ? (rem_sh - {1'b0, b_mag}) : rem_sh;
        quo_full = {quo[QW-2:0], qbit};
        quo_nxt  = quo_full;
        dvd_nxt  = {dvd[QW-2:0], 1'b0};
        cnt_nxt  = cnt - CW'(1);
        if (cnt == '0) begin
          // Any integer bits beyond the output range mean saturation.
          ovf_c       = |quo_full[QW-1:N-1];
          mag         = ovf_c ? {(N-1){1'b1}} : quo_full[N-2:0];
          q_nxt       = {sign & (|mag), mag};
          out_tag_nxt = tag;
          ovf_nxt     = ovf_c;
          dz_nxt      = 1'b0;
          state_nxt   = DONE;
        end
      end

      DONE: begin
        if (!out_valid) begin
          valid_nxt = 1'b1;
        end else if (out_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
